// File: rtl/useq.sv
// Microcode step sequencer: latches opcode/operand bytes from the fetch stream and
// steps the microcode ROM index until end-of-instruction, with halt, stall and traps.
module useq #(
   parameter int unsigned STEPS         = 8,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_valid,
   input  logic [7:0]                 fetch_data,
   output logic                       fetch_ready,
   input  logic [1:0]                 len_in,
   input  logic                       uend,
   input  logic                       stall,
   input  logic                       halt,
   output logic [7:0]                 insn,
   output logic [7:0]                 d1,
   output logic [7:0]                 d2,
   output logic [7:0]                 d3,
   output logic [$clog2(STEPS)-1:0]   is,
   output logic                       exec,
   output logic                       retire,
   output logic                       halted,
   output logic                       fault
);

   localparam int unsigned IW = $clog2(STEPS);
   localparam logic [IW-1:0] IS_LAST = IW'(STEPS - 1);
   localparam int unsigned WW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
   localparam bit TO_EN = (FETCH_TIMEOUT != 0);

   typedef enum logic [2:0] {
      StFetchOp,
      StDecode,
      StFetchOpr,
      StExec,
      StHalt,
      StFault
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      insn_q, insn_d;
   logic [7:0]      d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic [IW-1:0]   is_q, is_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [1:0]      opr_q, opr_d;
   logic [1:0]      len_q, len_d;
   logic            armed_q;
   logic            take;

   // armed_q keeps fetch_ready low until the first edge after reset release
   assign fetch_ready = armed_q && (state_q == StFetchOp || state_q == StFetchOpr);
   assign take        = fetch_valid & fetch_ready;

   assign insn = insn_q;
   assign d1   = d1_q;
   assign d2   = d2_q;
   assign d3   = d3_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFetchOp;
         insn_q  <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         d3_q    <= '0;
         is_q    <= '0;
         wait_q  <= '0;
         opr_q   <= '0;
         len_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         insn_q  <= insn_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         d3_q    <= d3_d;
         is_q    <= is_d;
         wait_q  <= wait_d;
         opr_q   <= opr_d;
         len_q   <= len_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      insn_d  = insn_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      d3_d    = d3_q;
      is_d    = is_q;
      wait_d  = wait_q;
      opr_d   = opr_q;
      len_d   = len_q;
      exec    = 1'b0;
      retire  = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      is      = '0;

      // starved-fetch watchdog, shared by both fetch states
      if (state_q == StFetchOp || state_q == StFetchOpr) begin
         if (take) begin
            wait_d = '0;
         end else if (!fetch_valid && TO_EN) begin
            if (wait_q == WAIT_LAST) state_d = StFault;
            else                     wait_d  = wait_q + WW'(1);
         end
      end

      case (state_q)
         StFetchOp: begin
            if (take) begin
               insn_d  = fetch_data;
               d1_d    = '0;
               d2_d    = '0;
               d3_d    = '0;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (len_in == 2'd0) begin
               state_d = StExec;
            end else begin
               len_d   = len_in;
               opr_d   = '0;
               state_d = StFetchOpr;
            end
         end
         StFetchOpr: begin
            if (take) begin
               case (opr_q)
                  2'd0:    d1_d = fetch_data;
                  2'd1:    d2_d = fetch_data;
                  default: d3_d = fetch_data;
               endcase
               if (opr_q == len_q - 2'd1) state_d = StExec;
               else                       opr_d   = opr_q + 2'd1;
            end
         end
         StExec: begin
            exec = 1'b1;
            is   = is_q;
            if (stall) begin
               is_d = is_q;
            end else if (uend) begin
               retire  = 1'b1;
               is_d    = '0;
               state_d = halt ? StHalt : StFetchOp;
            end else if (is_q == IS_LAST) begin
               is_d    = '0;
               state_d = StFault;
            end else begin
               is_d = is_q + IW'(1);
            end
         end
         StHalt: begin
            halted = 1'b1;
            if (!halt) state_d = StFetchOp;
         end
         StFault: begin
            fault = 1'b1;
         end
         default: begin
            state_d = StFault;
         end
      endcase
   end

endmodule

// File: tb/tb_useq.sv
// Directed self-checking bench for the useq microcode step sequencer.
module tb_useq;

   logic       clk;
   logic       rst;
   logic       fetch_valid;
   logic [7:0] fetch_data;
   logic       fetch_ready;
   logic [1:0] len_in;
   logic       uend;
   logic       stall;
   logic       halt;
   logic [7:0] insn, d1, d2, d3;
   logic [2:0] is;
   logic       exec, retire, halted, fault;

   int total = 0;
   int bad   = 0;

   useq #(.STEPS(8), .FETCH_TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_ready (fetch_ready),
      .len_in      (len_in),
      .uend        (uend),
      .stall       (stall),
      .halt        (halt),
      .insn        (insn),
      .d1          (d1),
      .d2          (d2),
      .d3          (d3),
      .is          (is),
      .exec        (exec),
      .retire      (retire),
      .halted      (halted),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; fetch_valid = 1'b0; fetch_data = 8'h00; len_in = 2'd0;
      uend = 1'b0; stall = 1'b0; halt = 1'b0;
      #3;
      chk("rst_ready", 32'(fetch_ready), 0);
      chk("rst_insn", 32'(insn), 0);
      chk("rst_is", 32'(is), 0);
      chk("rst_exec", 32'(exec), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_retire", 32'(retire), 0);
      #4 rst = 1'b1;
      #1 chk("ready_pre_arm", 32'(fetch_ready), 0);
      tick();
      chk("ready_armed", 32'(fetch_ready), 1);

      // len 0 opcode, uend at step 2
      fetch_valid = 1'b1; fetch_data = 8'h12; len_in = 2'd0;
      tick();
      chk("t1_insn", 32'(insn), 32'h12);
      chk("t1_decode_ready", 32'(fetch_ready), 0);
      chk("t1_decode_exec", 32'(exec), 0);
      fetch_valid = 1'b0;
      tick();
      chk("t1_exec0", 32'(exec), 1);
      chk("t1_is0", 32'(is), 0);
      chk("t1_noretire0", 32'(retire), 0);
      tick();
      chk("t1_is1", 32'(is), 1);
      chk("t1_noretire1", 32'(retire), 0);
      tick();
      chk("t1_is2", 32'(is), 2);
      uend = 1'b1;
      #1 chk("t1_retire", 32'(retire), 1);
      tick();
      uend = 1'b0;
      #1;
      chk("t1_exec_done", 32'(exec), 0);
      chk("t1_retire_once", 32'(retire), 0);
      chk("t1_ready_again", 32'(fetch_ready), 1);

      // three operands back-to-back
      fetch_valid = 1'b1; fetch_data = 8'hA0; len_in = 2'd3;
      tick();
      chk("t2_insn", 32'(insn), 32'hA0);
      fetch_data = 8'h11;
      tick();
      chk("t2_opr_ready", 32'(fetch_ready), 1);
      chk("t2_noexec_a", 32'(exec), 0);
      len_in = 2'd0;
      tick();
      chk("t2_d1", 32'(d1), 32'h11);
      fetch_data = 8'h22;
      tick();
      chk("t2_d2", 32'(d2), 32'h22);
      chk("t2_noexec_b", 32'(exec), 0);
      fetch_data = 8'h33;
      tick();
      chk("t2_d3", 32'(d3), 32'h33);
      chk("t2_exec", 32'(exec), 1);
      chk("t2_is0", 32'(is), 0);
      fetch_valid = 1'b0;
      uend = 1'b1;
      #1 chk("t2_retire", 32'(retire), 1);
      tick();
      uend = 1'b0;

      // stall overrides uend
      fetch_valid = 1'b1; fetch_data = 8'h33; len_in = 2'd0;
      tick();
      chk("t3_d1_cleared", 32'(d1), 0);
      fetch_valid = 1'b0;
      tick();
      tick();
      chk("t3_is1", 32'(is), 1);
      stall = 1'b1; uend = 1'b1;
      #1 chk("t3_stall_noretire_a", 32'(retire), 0);
      tick();
      chk("t3_hold_a", 32'(is), 1);
      chk("t3_stall_noretire_b", 32'(retire), 0);
      tick();
      chk("t3_hold_b", 32'(is), 1);
      stall = 1'b0;
      #1 chk("t3_retire", 32'(retire), 1);
      tick();
      uend = 1'b0;
      #1;
      chk("t3_exec_done", 32'(exec), 0);
      chk("t3_ready", 32'(fetch_ready), 1);

      // halt at step 1 of a 4-step instruction
      fetch_valid = 1'b1; fetch_data = 8'h66;
      tick();
      fetch_valid = 1'b0;
      tick();
      tick();
      chk("t6_is1", 32'(is), 1);
      halt = 1'b1;
      tick();
      tick();
      chk("t6_is3", 32'(is), 3);
      chk("t6_not_halted", 32'(halted), 0);
      uend = 1'b1;
      #1 chk("t6_retire", 32'(retire), 1);
      tick();
      uend = 1'b0;
      #1;
      chk("t6_halted", 32'(halted), 1);
      chk("t6_halt_ready", 32'(fetch_ready), 0);
      chk("t6_halt_exec", 32'(exec), 0);
      fetch_valid = 1'b1; fetch_data = 8'hEE;
      tick();
      chk("t6_still_halted", 32'(halted), 1);
      chk("t6_insn_kept", 32'(insn), 32'h66);
      fetch_valid = 1'b0; halt = 1'b0;
      tick();
      chk("t6_unhalted", 32'(halted), 0);
      chk("t6_ready_back", 32'(fetch_ready), 1);

      // runaway microcode
      fetch_valid = 1'b1; fetch_data = 8'h44;
      tick();
      fetch_valid = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) begin
         chk("t4_step", 32'(is), 32'(k));
         chk("t4_no_fault", 32'(fault), 0);
         tick();
      end
      chk("t4_fault", 32'(fault), 1);
      chk("t4_exec_off", 32'(exec), 0);
      chk("t4_is_zero", 32'(is), 0);
      chk("t4_ready_off", 32'(fetch_ready), 0);
      fetch_valid = 1'b1; fetch_data = 8'h55;
      tick();
      tick();
      chk("t4_fault_sticky", 32'(fault), 1);
      chk("t4_insn_frozen", 32'(insn), 32'h44);
      fetch_valid = 1'b0;

      // fetch timeout after reset
      rst = 1'b0;
      #1 chk("t5_fault_cleared", 32'(fault), 0);
      #1 rst = 1'b1;
      for (int k = 0; k < 15; k++) tick();
      chk("t5_before_timeout", 32'(fault), 0);
      chk("t5_ready_waiting", 32'(fetch_ready), 1);
      tick();
      chk("t5_timeout_fault", 32'(fault), 1);

      // asynchronous reset mid-EXEC
      rst = 1'b0;
      #2 rst = 1'b1;
      tick();
      fetch_valid = 1'b1; fetch_data = 8'h77;
      tick();
      fetch_valid = 1'b0;
      tick();
      tick();
      chk("t5_exec_running", 32'(exec), 1);
      chk("t5_is1", 32'(is), 1);
      chk("t5_insn", 32'(insn), 32'h77);
      #2 rst = 1'b0;
      #1;
      chk("t5_async_is", 32'(is), 0);
      chk("t5_async_exec", 32'(exec), 0);
      chk("t5_async_insn", 32'(insn), 0);
      chk("t5_async_ready", 32'(fetch_ready), 0);
      #1 rst = 1'b1;
      #1 chk("t5_ready_pre_edge", 32'(fetch_ready), 0);
      tick();
      chk("t5_ready_post_edge", 32'(fetch_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
